gray_pipe: RTL and testbench
============================

Name: gray_pipe

Overview:
Parametrised, pipelined RGB565-to-grayscale converter. It processes LANES pixels per beat under valid/ready flow control, with run-time programmable luma coefficients and a frame counter that generates last and done.
It sits between the frame-buffer read FIFO (RWM_1 side) and the grayscale store (RWM_2 side), and is started and monitored by the controller.

Parameters:
IMG_W, 1280, pixels per line
IMG_H, 720, lines per frame
LANES, 1, pixels per beat (1, 2 or 4); IMG_W*IMG_H must be divisible by LANES
BEATS, IMG_W*IMG_H/LANES, derived localparam: beats per frame

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse; begins a frame when in IDLE, ignored otherwise
abort  in  1  cancels the current frame from any state
coef_r  in  8  red weight, Q0.8, sampled on accepted start
coef_g  in  8  green weight, Q0.8, sampled on accepted start
coef_b  in  8  blue weight, Q0.8, sampled on accepted start
in_data  in  16*LANES  lane k in bits [16k+15:16k]; R=[15:11], G=[10:5], B=[4:0]
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
out_data  out  8*LANES  lane k gray value in bits [8k+7:8k]
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts when out_valid && out_ready
out_last  out  1  high with the final beat of the frame
busy  out  1  high in RUN and FLUSH
done  out  1  one-cycle pulse after the final beat is accepted downstream

Behaviour:
- Reset: state=IDLE; in_ready, out_valid, out_last, busy and done are 0; out_data is 0; beat counter is 0; coefficients reset to 77/150/29.
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE -> RUN on start; latches the coefficients and clears the beat counter.
  - RUN -> FLUSH on the cycle the BEATS-th input beat is accepted.
  - FLUSH -> DONE when the pipeline is empty and the out_last beat has been accepted.
  - DONE -> IDLE unconditionally; done=1 only in DONE.
- abort: any state -> IDLE next cycle. Pipeline valid bits are cleared, no done is produced, out_valid drops the next cycle.
- abort has priority over start and over input/output handshakes in the same cycle.
- Expansion per lane, by bit replication:
  - R8={R5,R5[4:2]}
  - G8={G6,G6[5:4]}
  - B8={B5,B5[4:2]}
- Arithmetic per lane:
  - Stage 1 registers three 16-bit products coef_x*X8.
  - Stage 2 registers the 18-bit sum >>8, saturated to 8'hFF if above 255.
- Latency: 2 cycles from input acceptance to out_valid when there is no backpressure. Throughput is 1 beat/cycle.
- Stall: stall = out_valid && !out_ready. When stalled, both stages hold and out_data stays stable.
- in_ready = (state==RUN) && !stall. Bubbles propagate as per-stage valid bits.
- out_last travels with the BEATS-th beat through the pipeline.
- Boundaries:
  - in_valid in IDLE, FLUSH or DONE is not accepted (in_ready=0).
  - start while busy is ignored.
  - The beat counter wraps to 0 on entry to RUN only.
  - Coefficient changes mid-frame have no effect.
  - Reset mid-frame: immediate return to reset values.

Optional Feature:
GRAY_ROUND_EN
- Defined: adds 128 to the 18-bit sum before >>8 (round-half-up), then saturates.
- Undefined: truncates the sum.

Test Plan:
- Default coefs, LANES=1, pixel 16'hFFFF -> out_data 8'hFF (255) two cycles after acceptance.
- Pixels 16'hF800 / 16'h07E0 / 16'h001F -> 76 / 149 / 28 truncated; 77 / 149 / 29 with GRAY_ROUND_EN.
- coef 255/255/255, pixel 16'hFFFF -> sum 762 saturates to 8'hFF.
- IMG_W=4, IMG_H=2, LANES=2, 4 beats streamed -> 4 output beats, out_last on the 4th, done pulses once 1 cycle after the last is accepted, then IDLE.
- out_ready held low 5 cycles mid-stream -> in_ready=0, out_data stable, no beat lost or duplicated; order preserved.
- abort asserted after beat 2 of 4 -> IDLE next cycle, out_valid=0, no done; a new start then runs a full frame correctly.

Source files
------------

// File: rtl/gray_pipe.sv
// Two-stage RGB565-to-grayscale pipeline, LANES pixels per beat, with frame counter and FSM.
// Define GRAY_ROUND_EN to round half-up before the >>8 instead of truncating.
module gray_pipe #(
  parameter int unsigned IMG_W = 1280,
  parameter int unsigned IMG_H = 720,
  parameter int unsigned LANES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [7:0]           coef_r,
  input  logic [7:0]           coef_g,
  input  logic [7:0]           coef_b,
  input  logic [16*LANES-1:0]  in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [8*LANES-1:0]   out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned BEATS = IMG_W * IMG_H / LANES;
  localparam int unsigned CW    = $clog2(BEATS + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

  state_e          state_q;
  logic [CW-1:0]   beat_cnt_q;
  logic [7:0]      coef_r_q, coef_g_q, coef_b_q;
  logic            s1_valid_q, s1_last_q;
  logic [15:0]     prod_r_q [LANES];
  logic [15:0]     prod_g_q [LANES];
  logic [15:0]     prod_b_q [LANES];

  logic            stall, accept, last_in;
  logic [7:0]      r8 [LANES];
  logic [7:0]      g8 [LANES];
  logic [7:0]      b8 [LANES];
  logic [17:0]     sum [LANES];
  logic [9:0]      shifted [LANES];
  logic [8*LANES-1:0] gray;

  assign stall    = out_valid && !out_ready;
  assign in_ready = (state_q == StRun) && !stall;
  assign accept   = in_valid && in_ready;
  assign last_in  = (beat_cnt_q == CW'(BEATS - 1));

  // Bit replication keeps full-scale 5/6-bit inputs mapping to 255.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      r8[k] = {in_data[16*k+11 +: 5], in_data[16*k+13 +: 3]};
      g8[k] = {in_data[16*k+5 +: 6], in_data[16*k+9 +: 2]};
      b8[k] = {in_data[16*k +: 5], in_data[16*k+2 +: 3]};
    end
  end

  always_comb begin
    gray = '0;
    for (int k = 0; k < LANES; k++) begin
      sum[k] = 18'(prod_r_q[k]) + 18'(prod_g_q[k]) + 18'(prod_b_q[k]);
`ifdef GRAY_ROUND_EN
      sum[k] = sum[k] + 18'd128;
`else
      sum[k] = sum[k];
`endif
      shifted[k] = 10'(sum[k] >> 8);
      gray[8*k +: 8] = (shifted[k][9:8] != 2'b00) ? 8'hFF : shifted[k][7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      beat_cnt_q <= '0;
      coef_r_q   <= 8'd77;
      coef_g_q   <= 8'd150;
      coef_b_q   <= 8'd29;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (abort) begin
      state_q <= StIdle;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StRun;
            busy       <= 1'b1;
            beat_cnt_q <= '0;
            coef_r_q   <= coef_r;
            coef_g_q   <= coef_g;
            coef_b_q   <= coef_b;
          end
        end
        StRun: begin
          if (accept) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (last_in) state_q <= StFlush;
          end
        end
        StFlush: begin
          // The tagged last beat is the final one, so its acceptance leaves the pipe empty.
          if (out_valid && out_ready && out_last) begin
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
      for (int k = 0; k < LANES; k++) begin
        prod_r_q[k] <= '0;
        prod_g_q[k] <= '0;
        prod_b_q[k] <= '0;
      end
    end else if (abort) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
    end else if (!stall) begin
      s1_valid_q <= accept;
      s1_last_q  <= accept && last_in;
      if (accept) begin
        for (int k = 0; k < LANES; k++) begin
          prod_r_q[k] <= coef_r_q * r8[k];
          prod_g_q[k] <= coef_g_q * g8[k];
          prod_b_q[k] <= coef_b_q * b8[k];
        end
      end
      out_valid <= s1_valid_q;
      out_last  <= s1_valid_q && s1_last_q;
      if (s1_valid_q) out_data <= gray;
    end
  end

endmodule

// File: tb/tb_gray_pipe.sv
// Directed, table-driven bench for gray_pipe with a 4x2 frame and two lanes (4 beats per frame).
module tb_gray_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [7:0]  coef_r, coef_g, coef_b;
  logic [31:0] in_data;
  logic        in_valid, in_ready;
  logic [15:0] out_data;
  logic        out_valid, out_ready, out_last, busy, done;

  gray_pipe #(.IMG_W(4), .IMG_H(2), .LANES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .coef_r   (coef_r),
    .coef_g   (coef_g),
    .coef_b   (coef_b),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  cr, cg, cb;
    logic [15:0] p0, p1;
    logic [7:0]  t0, t1;   // truncated results
    logic [7:0]  r0, r1;   // rounded results
  } vec_t;

  vec_t vecs [8];
  int   checks = 0;
  int   errors = 0;
  int   cyc_no = 0;
  int   done_cnt = 0;
  int   first_acc_cyc;

  always @(posedge clk) begin
    cyc_no <= cyc_no + 1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_of(input vec_t v);
`ifdef GRAY_ROUND_EN
    return {v.r1, v.r0};
`else
    return {v.t1, v.t0};
`endif
  endfunction

  task automatic drive_frame(input int base, input int nbeats);
    int w;
    @(posedge clk); #1;
    coef_r = vecs[base].cr; coef_g = vecs[base].cg; coef_b = vecs[base].cb;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    // Post-start coefficient changes must not affect the frame.
    coef_r = 8'd0; coef_g = 8'd0; coef_b = 8'd0;
    for (int b = 0; b < nbeats; b++) begin
      in_valid = 1'b1;
      in_data  = {vecs[base+b].p1, vecs[base+b].p0};
      if (b == 2) start = 1'b1;  // ignored while busy
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!in_ready && w < 100);
      if (!in_ready) begin
        chk("in handshake timeout", 32'd0, 32'd1);
        break;
      end
      if (b == 0) first_acc_cyc = cyc_no;
      @(posedge clk); #1;
      start = 1'b0;
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic check_frame(input int base, input bit do_stall);
    int got = 0, cyc = 0, stall_left = 0, dc;
    bit stalling = 0;
    logic [15:0] held = '0;
    dc = done_cnt;
    out_ready = 1'b1;
    while (got < 4 && cyc < 300) begin
      @(posedge clk); #1;
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (!out_ready) begin
        if (!stalling) begin
          held = out_data;
          stalling = 1;
          chk("stall out_valid", {31'd0, out_valid}, 32'd1);
        end else begin
          chk("stall out_data hold", {16'd0, out_data}, {16'd0, held});
        end
        chk("stall in_ready", {31'd0, in_ready}, 32'd0);
      end else if (out_valid) begin
        if (got == 0) chk("latency", 32'(cyc_no - first_acc_cyc), 32'd2);
        chk($sformatf("data f%0d b%0d", base / 4, got), {16'd0, out_data},
            {16'd0, exp_of(vecs[base+got])});
        chk($sformatf("last f%0d b%0d", base / 4, got), {31'd0, out_last},
            {31'd0, (got == 3)});
        got++;
        if (do_stall && got == 1) stall_left = 5;
      end
    end
    chk("frame beat count", 32'(got), 32'd4);
    @(negedge clk);
    chk("done pulse", {31'd0, done}, 32'd1);
    chk("busy in done", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("done cleared", {31'd0, done}, 32'd0);
    chk("idle in_ready", {31'd0, in_ready}, 32'd0);
    chk("single done", 32'(done_cnt - dc), 32'd1);
  endtask

  task automatic run_frame(input int base, input bit do_stall);
    fork
      drive_frame(base, 4);
      check_frame(base, do_stall);
    join
  endtask

  initial begin
    int dc;
    // Frame A: default weights 77/150/29.
    vecs[0] = '{8'd77, 8'd150, 8'd29, 16'hFFFF, 16'hF800, 8'd255, 8'd76, 8'd255, 8'd77};
    vecs[1] = '{8'd77, 8'd150, 8'd29, 16'h07E0, 16'h001F, 8'd149, 8'd28, 8'd149, 8'd29};
    vecs[2] = '{8'd77, 8'd150, 8'd29, 16'h0000, 16'hFFFF, 8'd0,   8'd255, 8'd0,  8'd255};
    vecs[3] = '{8'd77, 8'd150, 8'd29, 16'h8410, 16'h001F, 8'd130, 8'd28, 8'd131, 8'd29};
    // Frame B: weights 255/255/255, exercises saturation.
    vecs[4] = '{8'd255, 8'd255, 8'd255, 16'hFFFF, 16'h0000, 8'd255, 8'd0,   8'd255, 8'd0};
    vecs[5] = '{8'd255, 8'd255, 8'd255, 16'hF800, 16'h07E0, 8'd254, 8'd254, 8'd254, 8'd254};
    vecs[6] = '{8'd255, 8'd255, 8'd255, 16'h001F, 16'h0821, 8'd254, 8'd19,  8'd254, 8'd20};
    vecs[7] = '{8'd255, 8'd255, 8'd255, 16'h8410, 16'h0000, 8'd255, 8'd0,   8'd255, 8'd0};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    coef_r = '0; coef_g = '0; coef_b = '0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready",  {31'd0, in_ready},  32'd0);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset out_last",  {31'd0, out_last},  32'd0);
    chk("reset busy",      {31'd0, busy},      32'd0);
    chk("reset done",      {31'd0, done},      32'd0);
    chk("reset out_data",  {16'd0, out_data},  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    in_valid = 1'b1;
    @(negedge clk);
    chk("idle rejects input", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;

    run_frame(0, 1'b0);
    run_frame(4, 1'b1);

    // Abort after two of four beats.
    dc = done_cnt;
    drive_frame(0, 2);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort busy",      {31'd0, busy},      32'd0);
    chk("abort in_ready",  {31'd0, in_ready},  32'd0);
    repeat (5) @(negedge clk);
    chk("abort no done", 32'(done_cnt - dc), 32'd0);
    chk("abort stays idle", {31'd0, out_valid}, 32'd0);

    run_frame(0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
